// File: rtl/instr_loader_pkg.sv
// Shared state encoding and constants for the boot-time instruction loader.
// INSTR_LOADER_CHECKSUM_EN adds the CHECK state used for the trailing checksum byte.
package loader_pkg;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned DEFAULT_ADDR_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_RUN,
        ST_ERR
    } state_t;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = loader side, slave = byte source / memory side.
interface instr_loader_if;

    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;

    modport master (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_data_o
    );

    modport slave (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_data_o
    );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Assembles little-endian 32-bit words from accepted bytes; word_done_o pulses
// combinationally with the 4th byte so word_o already contains it.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    localparam int unsigned      CNT_W = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD_BYTES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      shift_q, shift_d;

    // Newest byte enters at the top, so byte 0 ends up in bits [7:0].
    assign word_o      = {byte_i, shift_q};
    assign word_done_o = accept_i && (cnt_q == LAST);

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (accept_i) begin
            cnt_d   = word_done_o ? '0 : cnt_q + CNT_W'(1);
            shift_d = word_o[31:8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: fills instruction memory from a byte stream, then raises start_o.
// Optional trailing XOR checksum byte when INSTR_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | after reset, waiting for load_i
// RECV  | accepting stream bytes into the packer
// WRITE | one-cycle memory write of the assembled word
// CHECK | accepting the checksum byte (checksum build only)
// RUN   | load complete, CPU released
// ERR   | bad length or checksum; waits for a new load_i
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [ADDR_W:0] len_i,
    instr_loader_if.master  bus,
    output logic            start_o,
    output logic            busy_o,
    output logic            err_o
);

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] word_cnt_q;
    logic            byte_ready_q;
    logic            mem_we_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     mem_data_q;
    logic            start_q;
    logic            busy_q;
    logic            err_q;

    logic            load_ok;
    logic            len_bad;
    logic            byte_acc;
    logic            recv_acc;
    logic            last_word;
    logic            word_done;
    logic [31:0]     packed_word;
    logic            ready_d;
    logic            busy_d;

    assign load_ok   = load_i && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERR);
    assign len_bad   = (len_i == '0) || (len_i > CAP);
    assign byte_acc  = bus.byte_valid_i && byte_ready_q;
    assign recv_acc  = byte_acc && (state_q == ST_RECV);
    assign last_word = (word_cnt_q + (ADDR_W+1)'(1)) == len_q;

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (load_ok),
        .accept_i    (recv_acc),
        .byte_i      (bus.byte_data_i),
        .word_o      (packed_word),
        .word_done_o (word_done)
    );

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            xor_q <= '0;
        end else if (load_ok) begin
            xor_q <= '0;
        end else if (recv_acc) begin
            xor_q <= xor_q ^ bus.byte_data_i;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (load_i) state_d = len_bad ? ST_ERR : ST_RECV;
            end
            ST_RECV: begin
                if (word_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_RUN;
`endif
                end else begin
                    state_d = ST_RECV;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_acc) state_d = (bus.byte_data_i == xor_q) ? ST_RUN : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        ready_d = (state_d == ST_RECV);
        busy_d  = (state_d == ST_RECV) || (state_d == ST_WRITE);
`ifdef INSTR_LOADER_CHECKSUM_EN
        ready_d = ready_d || (state_d == ST_CHECK);
        busy_d  = busy_d  || (state_d == ST_CHECK);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= ready_d;
            busy_q       <= busy_d;
            start_q      <= (state_d == ST_RUN);
            err_q        <= (state_d == ST_ERR);
            mem_we_q     <= word_done;
            if (word_done) begin
                mem_addr_q <= word_addr(BASE_ADDR, 32'(word_cnt_q));
                mem_data_q <= packed_word;
            end
            if (load_ok && !len_bad) begin
                len_q      <= len_i;
                word_cnt_q <= '0;
            end else if (state_q == ST_WRITE) begin
                word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
            end
        end
    end

    assign bus.byte_ready_o = byte_ready_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign start_o          = start_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: length table, directed timing sequences,
// and a randomized-gap stream compared against a memory-image model.
module tb_instr_loader;

    localparam int ADDR_W = 10;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            load  = 1'b0;
    logic [ADDR_W:0] len   = '0;
    logic            start, busy, err;

    instr_loader_if bus();

    instr_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .load_i  (load),
        .len_i   (len),
        .bus     (bus),
        .start_o (start),
        .busy_o  (busy),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    int          vec_cnt     = 0;
    int          miscompares = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] exp_w[$];
    logic [7:0]  xor_acc;

    typedef struct {
        logic [ADDR_W:0] len;
        logic            exp_err;
        logic            exp_busy;
    } len_vec_t;

    len_vec_t lv[6];

    always @(negedge clk) begin
        if (rst_n && bus.mem_we_o) begin
            wr_addr.push_back(bus.mem_addr_o);
            wr_data.push_back(bus.mem_data_o);
        end
        if (start && err) begin
            miscompares++;
            $display("FAIL start_err_exclusive: start_o=%0b err_o=%0b, required not both 1", start, err);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        vec_cnt++;
        miscompares++;
        $display("FAIL %s: timeout, got no event, expected one", name);
    endtask

    task automatic do_reset();
        bus.byte_valid_i = 1'b0;
        load             = 1'b0;
        rst_n            = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        exp_w.delete();
        xor_acc = 8'h00;
    endtask

    task automatic pulse_load(input logic [ADDR_W:0] l);
        load = 1'b1;
        len  = l;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = b;
        n = 0;
        while (!bus.byte_ready_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready_o) fail_timeout("byte_ready_o");
        else @(negedge clk);
        bus.byte_valid_i = 1'b0;
    endtask

    // Reference model: a word lands in memory as its four stream bytes, LSB first.
    task automatic push_word(input logic [31:0] w);
        exp_w.push_back(w);
        xor_acc = xor_acc ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        push_word(w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], int'($urandom_range(0, maxgap)));
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_o_done", 32'(start), 32'd1);
    endtask

    task automatic finish_load();
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(xor_acc, 0);
`endif
        wait_start();
    endtask

    task automatic check_image(input int n);
        check("wr_count", 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size() && i < exp_w.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), wr_addr[i], 32'(4 * i));
            check($sformatf("wr_data[%0d]", i), wr_data[i], exp_w[i]);
        end
    endtask

    initial begin
        logic [31:0] w;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;
        xor_acc          = 8'h00;

        lv[0] = '{len: 11'd0,    exp_err: 1'b1, exp_busy: 1'b0};
        lv[1] = '{len: 11'd1025, exp_err: 1'b1, exp_busy: 1'b0};
        lv[2] = '{len: 11'd2047, exp_err: 1'b1, exp_busy: 1'b0};
        lv[3] = '{len: 11'd1,    exp_err: 1'b0, exp_busy: 1'b1};
        lv[4] = '{len: 11'd1024, exp_err: 1'b0, exp_busy: 1'b1};
        lv[5] = '{len: 11'd7,    exp_err: 1'b0, exp_busy: 1'b1};

        // Reset values
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_byte_ready", 32'(bus.byte_ready_o), 32'd0);
        check("rst_mem_we",     32'(bus.mem_we_o),     32'd0);
        check("rst_mem_addr",   bus.mem_addr_o,        32'd0);
        check("rst_mem_data",   bus.mem_data_o,        32'd0);
        check("rst_start",      32'(start),            32'd0);
        check("rst_busy",       32'(busy),             32'd0);
        check("rst_err",        32'(err),              32'd0);
        do_reset();

        // Length table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            pulse_load(lv[i].len);
            check($sformatf("len%0d_err", lv[i].len),   32'(err),              32'(lv[i].exp_err));
            check($sformatf("len%0d_busy", lv[i].len),  32'(busy),             32'(lv[i].exp_busy));
            check($sformatf("len%0d_ready", lv[i].len), 32'(bus.byte_ready_o), 32'(lv[i].exp_busy));
            check($sformatf("len%0d_start", lv[i].len), 32'(start),            32'd0);
            if (lv[i].exp_err) begin
                repeat (3) @(negedge clk);
                check("err_no_writes", 32'(wr_addr.size()), 32'd0);
                check("err_sticky",    32'(err),            32'd1);
                pulse_load(11'd1);
                check("err_cleared_by_load", 32'(err),  32'd0);
                check("busy_after_err_load", 32'(busy), 32'd1);
            end
        end

        // Two-word program, no backpressure
        do_reset();
        pulse_load(11'd2);
        check("ready_at_t1", 32'(bus.byte_ready_o), 32'd1);
        send_word(32'h00500013, 0);
        check("we_after_word0", 32'(bus.mem_we_o), 32'd1);
        send_word(32'h00100093, 0);
`ifndef INSTR_LOADER_CHECKSUM_EN
        check("we_after_word1", 32'(bus.mem_we_o), 32'd1);
        check("start_at_t1",    32'(start),        32'd0);
        @(negedge clk);
        check("start_at_t2",    32'(start),        32'd1);
        check("we_one_cycle",   32'(bus.mem_we_o), 32'd0);
        check("busy_in_run",    32'(busy),         32'd0);
`else
        finish_load();
`endif
        check_image(2);
        check("two_word_err", 32'(err), 32'd0);
        pulse_load(11'd1);
        check("start_drops_on_load", 32'(start), 32'd0);
        check("busy_on_reload",      32'(busy),  32'd1);

        // Randomized byte gaps over 16 words
        do_reset();
        pulse_load(11'd16);
        for (int i = 0; i < 16; i++) send_word($urandom, 5);
        finish_load();
        check_image(16);
        check("rand_busy_done", 32'(busy), 32'd0);

        // Asynchronous reset after 2 of 4 words, then a fresh 1-word load
        do_reset();
        pulse_load(11'd4);
        send_word($urandom, 0);
        send_word($urandom, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        check("wr_before_rst", 32'(wr_addr.size()), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_byte_ready", 32'(bus.byte_ready_o), 32'd0);
        check("arst_mem_we",     32'(bus.mem_we_o),     32'd0);
        check("arst_mem_addr",   bus.mem_addr_o,        32'd0);
        check("arst_mem_data",   bus.mem_data_o,        32'd0);
        check("arst_start",      32'(start),            32'd0);
        check("arst_busy",       32'(busy),             32'd0);
        check("arst_err",        32'(err),              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        exp_w.delete();
        xor_acc = 8'h00;
        pulse_load(11'd1);
        send_word(32'hCAFE0001, 0);
        finish_load();
        check_image(1);

        // load_i during WRITE and mid-word in RECV is ignored
        do_reset();
        pulse_load(11'd3);
        send_word(32'h11223344, 0);
        pulse_load(11'd1);
        w = 32'hA5B6C7D8;
        push_word(w);
        send_byte(w[7:0], 0);
        send_byte(w[15:8], 0);
        pulse_load(11'd5);
        send_byte(w[23:16], 0);
        send_byte(w[31:24], 0);
        repeat (3) @(negedge clk);
        check("ignored_load_no_start", 32'(start), 32'd0);
        check("ignored_load_busy",     32'(busy),  32'd1);
        send_word(32'h0BADF00D, 1);
        finish_load();
        check_image(3);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Checksum pass and fail on word 32'h00500013
        do_reset();
        pulse_load(11'd1);
        send_word(32'h00500013, 0);
        send_byte(8'h43, 0);
        check("cksum_ok_start", 32'(start), 32'd1);
        check("cksum_ok_err",   32'(err),   32'd0);
        do_reset();
        pulse_load(11'd1);
        send_word(32'h00500013, 0);
        send_byte(8'h00, 0);
        check("cksum_bad_err",   32'(err),   32'd1);
        check("cksum_bad_start", 32'(start), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that fills the instruction memory and then releases the CPU. It accepts a byte stream on a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written through a write port on the instruction memory, which the CPU fetch path reads. On successful completion it raises `start_o`, which drives the CPU `start_i`.

## Interface
- `ADDR_W`, 10: word-address width; capacity is 2^ADDR_W words.
- `BASE_ADDR`, 32'h0: byte address of the first word written.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `load_i`  in  1  one-cycle request to start a load; sampled only in IDLE, RUN or ERR.
- `len_i`  in  ADDR_W+1  number of words to load; sampled together with `load_i`.
- `byte_valid_i`  in  1  source has a byte.
- `byte_data_i`  in  8  stream byte.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `mem_we_o`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr_o`  out  32  byte address of the write, word aligned.
- `mem_data_o`  out  32  instruction word.
- `start_o`  out  1  CPU run enable.
- `busy_o`  out  1  load in progress.
- `err_o`  out  1  load failed; sticky until the next `load_i` or reset.

## Operation
- States: IDLE, RECV, WRITE, CHECK (present only with the macro), RUN, ERR.
- IDLE, RUN or ERR with `load_i`=1:
  - `len_i`==0 or `len_i`>2^ADDR_W → ERR.
  - Otherwise → RECV. Clear the word counter, byte counter and `err_o`. Drop `start_o`.
- RECV: `byte_ready_o`=1.
  - A byte transfers when valid&ready.
  - Byte k (0..3) goes into word bits [8k+7:8k].
  - After the 4th byte → WRITE.
- WRITE: `byte_ready_o`=0, `mem_we_o`=1.
  - `mem_addr_o` = BASE_ADDR + 4*word_cnt.
  - `mem_data_o` = assembled word.
  - Then word_cnt+1. If word_cnt+1==len → CHECK (macro) or RUN; otherwise → RECV.
- RUN: `start_o`=1, held until a new `load_i` or reset.
- `load_i` in RECV, WRITE or CHECK is ignored.
- `byte_valid_i` outside RECV/CHECK is ignored; no byte is consumed.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Reset values: `byte_ready_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `start_o`=0, `busy_o`=0, `err_o`=0. State is IDLE.
- Reset asserted mid-load aborts immediately. Memory contents already written are not undone.
- `load_i` at cycle t → `byte_ready_o`=1 at t+1.
- 4th byte accepted at cycle t → `mem_we_o` high during t+1 only.
- Single-word load, no backpressure: `start_o` rises at t+2, where t is the 4th-byte cycle.
- Minimum throughput is 5 cycles per word: 4 RECV cycles plus 1 WRITE cycle.
- `busy_o`=1 exactly in RECV, WRITE and CHECK.
- `err_o` and `start_o` are never both 1.
- All outputs are registered.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - After the last WRITE, enter CHECK with `byte_ready_o`=1.
  - Accept one byte and compare it with the XOR of all received bytes.
  - Equal → RUN; unequal → ERR.
- `INSTR_LOADER_CHECKSUM_EN` undefined: no CHECK state and no XOR register. The last WRITE goes straight to RUN.

## Structure
- Package `loader_pkg` holds:
  - the state enum;
  - `WORD_BYTES`=4;
  - the default `ADDR_W`.
- One sub-module, `byte_packer`: byte counter plus 32-bit shift assembly, with a `word_done` pulse output.
- The FSM, counters and output registers sit in `instr_loader`.

## Test plan
- Load two words, `len_i`=2, bytes 13,00,50,00,93,00,10,00 with no backpressure.
  - Required: writes 32'h00500013 at address 0 and 32'h00100093 at address 4.
  - `start_o`=1 two cycles after the last byte.
- `len_i`=0, or `len_i`=2^ADDR_W+1 → `err_o`=1 next cycle; no writes; `start_o`=0.
- Random `byte_valid_i` gaps of 0–5 cycles over 16 words → identical memory image, exactly 16 `mem_we_o` pulses.
- Assert `rst_i`=0 after 2 of 4 words:
  - all outputs return to reset values asynchronously;
  - a new load of 1 word then writes at address 0.
- `load_i` pulsed mid-load → ignored; the word count is unchanged.
- With `INSTR_LOADER_CHECKSUM_EN`, word 32'h00500013:
  - checksum 8'h43 → RUN;
  - checksum 8'h00 → `err_o`=1, `start_o`=0.
